// File: rtl/sprite_blitter_if.sv
// Request/pixel bus between a sprite requester and the blitter.
// Pixel outputs go to the VGA adapter write port.
interface sprite_blitter_if;
   logic       req_valid;
   logic       req_ready;
   logic [7:0] req_x;
   logic [6:0] req_y;
   logic [6:0] req_old_y;
   logic [3:0] req_w;
   logic [3:0] req_h;
   logic [2:0] req_colour;
   logic       req_move;
   logic       plot;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;
   logic       done;

   modport master (
      output req_valid, req_x, req_y, req_old_y, req_w, req_h, req_colour, req_move,
      input  req_ready, plot, x, y, colour, done
   );

   modport slave (
      input  req_valid, req_x, req_y, req_old_y, req_w, req_h, req_colour, req_move,
      output req_ready, plot, x, y, colour, done
   );
endinterface

// File: rtl/sprite_blitter.sv
// Rectangular sprite blitter: optional erase of the old box in BG_COLOUR,
// then a raster-order fill of the new box, one pixel per cycle, with clipping.
module sprite_blitter #(
   parameter int unsigned SCREEN_W  = 160,
   parameter int unsigned SCREEN_H  = 120,
   parameter logic [2:0]  BG_COLOUR = 3'b000
) (
   input  logic             clk,
   input  logic             reset,
   sprite_blitter_if.slave  bus
);
   localparam int unsigned XW   = 8;
   localparam int unsigned YW   = 7;
   localparam int unsigned XS_W = XW + 1;
   localparam int unsigned YS_W = YW + 1;

   typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_e;

   state_e          state_q, state_d;
   logic [XW-1:0]   bx_q, bx_d;
   logic [YW-1:0]   by_q, by_d;
   logic [YW-1:0]   boy_q, boy_d;
   logic [3:0]      w_q, w_d;
   logic [3:0]      h_q, h_d;
   logic [2:0]      col_q, col_d;
   logic [3:0]      cx_q, cx_d;
   logic [3:0]      cy_q, cy_d;

   logic            ready_q;
   logic            plot_q, plot_d;
   logic [XW-1:0]   x_q;
   logic [YW-1:0]   y_q;
   logic [2:0]      colour_q;
   logic            done_q;

   logic            visit;
   logic [XS_W-1:0] xs;
   logic [YS_W-1:0] ys;
   logic [2:0]      pcol;

   // Next state, counters and the pixel that will be presented next cycle.
   always_comb begin
      state_d = state_q;
      bx_d    = bx_q;
      by_d    = by_q;
      boy_d   = boy_q;
      w_d     = w_q;
      h_d     = h_q;
      col_d   = col_q;
      cx_d    = cx_q;
      cy_d    = cy_q;

      unique case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               bx_d    = bus.req_x;
               by_d    = bus.req_y;
               boy_d   = bus.req_old_y;
               w_d     = bus.req_w;
               h_d     = bus.req_h;
               col_d   = bus.req_colour;
               cx_d    = 4'd0;
               cy_d    = 4'd0;
               state_d = bus.req_move ? ERASE : DRAW;
            end
         end
         ERASE, DRAW: begin
            if (cx_q == w_q) begin
               cx_d = 4'd0;
               if (cy_q == h_q) begin
                  cy_d    = 4'd0;
                  state_d = (state_q == ERASE) ? DRAW : DONE;
               end else begin
                  cy_d = cy_q + 4'd1;
               end
            end else begin
               cx_d = cx_q + 4'd1;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Sums are one bit wider so a box hanging off the right/bottom edge clips rather than wraps.
      visit  = (state_d == ERASE) || (state_d == DRAW);
      xs     = {1'b0, bx_d} + XS_W'(cx_d);
      ys     = {1'b0, ((state_d == ERASE) ? boy_d : by_d)} + YS_W'(cy_d);
      pcol   = (state_d == ERASE) ? BG_COLOUR : col_d;
      plot_d = visit && (xs < XS_W'(SCREEN_W)) && (ys < YS_W'(SCREEN_H));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         bx_q     <= '0;
         by_q     <= '0;
         boy_q    <= '0;
         w_q      <= '0;
         h_q      <= '0;
         col_q    <= '0;
         cx_q     <= '0;
         cy_q     <= '0;
         ready_q  <= 1'b1;
         plot_q   <= 1'b0;
         x_q      <= '0;
         y_q      <= '0;
         colour_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         bx_q     <= bx_d;
         by_q     <= by_d;
         boy_q    <= boy_d;
         w_q      <= w_d;
         h_q      <= h_d;
         col_q    <= col_d;
         cx_q     <= cx_d;
         cy_q     <= cy_d;
         ready_q  <= (state_d == IDLE);
         plot_q   <= plot_d;
         x_q      <= visit ? xs[XW-1:0] : '0;
         y_q      <= visit ? ys[YW-1:0] : '0;
         colour_q <= visit ? pcol : 3'b000;
         done_q   <= (state_d == DONE);
      end
   end

   assign bus.req_ready = ready_q;
   assign bus.plot      = plot_q;
   assign bus.x         = x_q;
   assign bus.y         = y_q;
   assign bus.colour    = colour_q;
   assign bus.done      = done_q;
endmodule

// File: tb/tb_sprite_blitter.sv
// Directed and random requests against a pixel-list model of the blitter.
module tb_sprite_blitter;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   sprite_blitter_if bus ();

   sprite_blitter #(
      .SCREEN_W (160),
      .SCREEN_H (120),
      .BG_COLOUR(3'b000)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int errors = 0;
   int checks = 0;

   typedef struct {
      int x;
      int y;
      int c;
      bit plot;
   } pix_t;

   pix_t exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Every cycle of a request, in order: erase pass (if moving) then draw pass.
   task automatic build(input int rx, input int ry, input int roy, input int rw,
                        input int rh, input int rc, input bit mv);
      int yy, col;
      exp_q.delete();
      for (int p = (mv ? 0 : 1); p < 2; p++) begin
         yy  = (p == 0) ? roy : ry;
         col = (p == 0) ? 0 : rc;
         for (int r = 0; r <= rh; r++)
            for (int c = 0; c <= rw; c++) begin
               pix_t e;
               e.x    = rx + c;
               e.y    = yy + r;
               e.c    = col;
               e.plot = (rx + c < 160) && (yy + r < 120);
               exp_q.push_back(e);
            end
      end
   endtask

   task automatic drive(input int rx, input int ry, input int roy, input int rw,
                        input int rh, input int rc, input bit mv);
      bus.req_x      = 8'(rx);
      bus.req_y      = 7'(ry);
      bus.req_old_y  = 7'(roy);
      bus.req_w      = 4'(rw);
      bus.req_h      = 4'(rh);
      bus.req_colour = 3'(rc);
      bus.req_move   = mv;
   endtask

   // Present a request and return at the negedge of the first cycle after the handshake.
   task automatic start_req(input int rx, input int ry, input int roy, input int rw,
                            input int rh, input int rc, input bit mv, input bit expect_now,
                            output bit ok);
      int waits = 0;
      ok = 1'b0;
      @(negedge clk);
      drive(rx, ry, roy, rw, rh, rc, mv);
      bus.req_valid = 1'b1;
      while (bus.req_ready !== 1'b1) begin
         waits++;
         if (waits > 1000) begin
            check("ready_timeout", 32'd0, 32'd1);
            bus.req_valid = 1'b0;
            return;
         end
         @(negedge clk);
      end
      if (expect_now) check("accept_after_done", 32'(waits), 32'd0);
      build(rx, ry, roy, rw, rh, rc, mv);
      @(posedge clk);
      @(negedge clk);
      ok = 1'b1;
   endtask

   // Check every cycle up to done; optionally hold a new request on the bus while busy.
   task automatic run_req(input int rx, input int ry, input int roy, input int rw,
                          input int rh, input int rc, input bit mv, input bit expect_now,
                          input bit hold, input int nx, input int ny, input int noy,
                          input int nw, input int nh, input int nc, input bit nmv);
      bit ok;
      int len;
      start_req(rx, ry, roy, rw, rh, rc, mv, expect_now, ok);
      if (!ok) return;
      if (hold) drive(nx, ny, noy, nw, nh, nc, nmv);
      else begin
         bus.req_valid = 1'b0;
         drive($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 1'($urandom));
      end
      len = exp_q.size();
      for (int k = 1; k <= len + 1; k++) begin
         if (k > 1) @(negedge clk);
         check("ready_busy", 32'(bus.req_ready), 32'd0);
         if (k <= len) begin
            pix_t e = exp_q[k-1];
            check("plot", 32'(bus.plot), 32'(e.plot));
            if (e.plot) begin
               check("x", 32'(bus.x), 32'(e.x));
               check("y", 32'(bus.y), 32'(e.y));
               check("colour", 32'(bus.colour), 32'(e.c));
            end
            check("done_early", 32'(bus.done), 32'd0);
         end else begin
            check("plot_in_done", 32'(bus.plot), 32'd0);
            check("done_pulse", 32'(bus.done), 32'd1);
         end
      end
   endtask

   task automatic simple(input int rx, input int ry, input int roy, input int rw,
                         input int rh, input int rc, input bit mv);
      run_req(rx, ry, roy, rw, rh, rc, mv, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 1'b0);
   endtask

   initial begin
      bit ok;
      reset         = 1'b1;
      bus.req_valid = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 1'b0);
      #12;
      check("rst_plot", 32'(bus.plot), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_x", 32'(bus.x), 32'd0);
      check("rst_y", 32'(bus.y), 32'd0);
      check("rst_colour", 32'(bus.colour), 32'd0);
      check("rst_ready", 32'(bus.req_ready), 32'd1);
      @(negedge clk);
      reset = 1'b0;

      simple(20, 50, 0, 3, 3, 6, 1'b0);      // draw only
      simple(20, 54, 50, 3, 3, 6, 1'b1);     // move
      simple(158, 118, 0, 3, 3, 5, 1'b0);    // clipped corner
      simple(77, 33, 0, 0, 0, 7, 1'b0);      // single pixel
      simple(5, 40, 40, 2, 1, 2, 1'b1);      // erase and draw same place
      simple(250, 126, 125, 15, 15, 4, 1'b1); // fully off-screen, largest box

      // Back-pressure: second request held valid while the first is busy.
      run_req(10, 10, 0, 2, 2, 3, 1'b0, 1'b0, 1'b1, 100, 60, 57, 1, 2, 1, 1'b1);
      run_req(100, 60, 57, 1, 2, 1, 1'b1, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 1'b0);

      // Reset in the middle of a draw.
      start_req(30, 30, 0, 3, 3, 5, 1'b0, 1'b0, ok);
      bus.req_valid = 1'b0;
      repeat (6) @(negedge clk);
      check("pix7_plot", 32'(bus.plot), 32'd1);
      check("pix7_x", 32'(bus.x), 32'd32);
      check("pix7_y", 32'(bus.y), 32'd31);
      #2 reset = 1'b1;
      #1;
      check("abort_plot", 32'(bus.plot), 32'd0);
      check("abort_done", 32'(bus.done), 32'd0);
      check("abort_x", 32'(bus.x), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         check("post_rst_ready", 32'(bus.req_ready), 32'd1);
         check("post_rst_plot", 32'(bus.plot), 32'd0);
         check("post_rst_done", 32'(bus.done), 32'd0);
      end

      for (int i = 0; i < 12; i++)
         simple($urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 127),
                $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 7),
                1'($urandom));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
